// File: rtl/instruction_fetch_if.sv
// ---------------------------------------------------------------------------
// instruction_fetch_if
//   Blocking I-cache read handshake between the IF stage and the I-cache.
//
//   icache_read   fetch -> cache  read request, held until icache_resp
//   icache_addr   fetch -> cache  word address, stable while a request waits
//   icache_resp   cache -> fetch  one-cycle response strobe
//   icache_rdata  cache -> fetch  instruction word, valid with icache_resp
//
//   master: the fetch stage.  slave: the I-cache.
// ---------------------------------------------------------------------------
interface instruction_fetch_if;
    logic        icache_read;
    logic [31:0] icache_addr;
    logic        icache_resp;
    logic [31:0] icache_rdata;

    modport master (
        output icache_read,
        output icache_addr,
        input  icache_resp,
        input  icache_rdata
    );

    modport slave (
        input  icache_read,
        input  icache_addr,
        output icache_resp,
        output icache_rdata
    );
endinterface

// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//   IF stage of the 5-stage RV32I pipeline. Owns the fetch PC, drives the
//   blocking I-cache handshake and holds the IF/ID register feeding decode.
//   Handles decode back-pressure, branch redirects and the discard of an
//   in-flight response made stale by a redirect.
//
//   Ports:
//     clk, rst      clock, synchronous active-high reset
//     br_taken      redirect + flush from EX
//     br_target     redirect address (low bits passed through unchanged)
//     bubble        decode hazard stall, IF/ID holds
//     MA_stall      memory-stage stall, IF/ID holds
//     icache        I-cache handshake (instruction_fetch_if.master)
//     PC_out        IF/ID PC
//     instr_out     IF/ID instruction
//     IF_stall      decode could advance but IF has nothing to deliver
//
//   Optional build macro IF_PERF_CNT_EN adds perf_fetch_cnt (real
//   instructions written to IF/ID) and perf_stall_cnt (cycles with IF_stall).
// ---------------------------------------------------------------------------
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0060,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                br_taken,
    input  logic [31:0]         br_target,
    input  logic                bubble,
    input  logic                MA_stall,
    instruction_fetch_if.master icache,
    output logic [31:0]         PC_out,
    output logic [31:0]         instr_out,
    output logic                IF_stall
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]         perf_fetch_cnt,
    output logic [31:0]         perf_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,  // request at pc outstanding
        S_HELD = 2'd1,  // word captured in hold_buf, waiting for decode
        S_DROP = 2'd2   // request at drop_addr outstanding, result discarded
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] drop_addr;
    logic [31:0] hold_buf;
    logic        adv;

    assign adv = !MA_stall && !bubble;

    // NOTE: every output of a combinational block gets a default first so a
    // missed branch can never infer a latch.
    always_comb begin
        icache.icache_read = 1'b1;
        icache.icache_addr = pc;
        case (state)
            S_HELD:  icache.icache_read = 1'b0;
            S_DROP:  icache.icache_addr = drop_addr;
            default: ;
        endcase
    end

    // Starved: decode wants a word but the only outstanding response is
    // either not here yet or destined for the bin. A redirect masks it.
    assign IF_stall = !br_taken && adv &&
                      ((state == S_REQ && !icache.icache_resp) || state == S_DROP);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_REQ;
            pc        <= RESET_PC;
            drop_addr <= '0;
            hold_buf  <= '0;
            PC_out    <= '0;
            instr_out <= NOP_INSTR;
        end else if (br_taken) begin
            pc        <= br_target;
            PC_out    <= '0;
            instr_out <= NOP_INSTR;
            case (state)
                S_REQ: begin
                    // Request already presented cannot be withdrawn; remember
                    // it so its address stays stable until the cache answers.
                    if (!icache.icache_resp) begin
                        drop_addr <= pc;
                        state     <= S_DROP;
                    end
                end
                S_HELD: state <= S_REQ;
                S_DROP: if (icache.icache_resp) state <= S_REQ;
                default: state <= S_REQ;
            endcase
        end else begin
            case (state)
                S_REQ: begin
                    if (icache.icache_resp) begin
                        if (adv) begin
                            PC_out    <= pc;
                            instr_out <= icache.icache_rdata;
                            pc        <= pc + 32'd4;
                        end else begin
                            hold_buf <= icache.icache_rdata;
                            state    <= S_HELD;
                        end
                    end else if (adv) begin
                        PC_out    <= '0;
                        instr_out <= NOP_INSTR;
                    end
                end
                S_HELD: begin
                    if (adv) begin
                        PC_out    <= pc;
                        instr_out <= hold_buf;
                        pc        <= pc + 32'd4;
                        state     <= S_REQ;
                    end
                end
                S_DROP: begin
                    if (icache.icache_resp) state <= S_REQ;
                    if (adv) begin
                        PC_out    <= '0;
                        instr_out <= NOP_INSTR;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

`ifdef IF_PERF_CNT_EN
    logic fetch_now;

    assign fetch_now = !br_taken && adv &&
                       ((state == S_REQ && icache.icache_resp) || state == S_HELD);

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (fetch_now) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (IF_stall)  perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch
//   Self-checking bench for instruction_fetch. A bench-side I-cache returns a
//   fixed function of the address after a chosen latency. A reference model
//   tracks what the fetch stage owes decode (next PC, a captured word, an
//   outstanding stale request) and is compared with the DUT every cycle.
//   Directed scenarios first pin the model with literal values, then a long
//   randomized run with stalls, redirects and resets.
// ---------------------------------------------------------------------------
module tb_instruction_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0060;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        br_taken;
    logic [31:0] br_target;
    logic        bubble;
    logic        MA_stall;
    logic [31:0] PC_out;
    logic [31:0] instr_out;
    logic        IF_stall;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    instruction_fetch_if icache ();

    instruction_fetch #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .br_taken  (br_taken),
        .br_target (br_target),
        .bubble    (bubble),
        .MA_stall  (MA_stall),
        .icache    (icache),
        .PC_out    (PC_out),
        .instr_out (instr_out),
        .IF_stall  (IF_stall)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Cache contents: never equal to the NOP encoding for addresses used here.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[29:0], 2'b11} ^ 32'h5A00_0000;
    endfunction

    // Reference model state
    logic [31:0] m_pc;
    logic        m_stale;
    logic [31:0] m_stale_addr;
    logic        m_held;
    logic [31:0] m_held_word;
    logic [31:0] exp_pc_out;
    logic [31:0] exp_instr;
    logic [31:0] exp_fetch;
    logic [31:0] exp_stall;

    // Bench cache state
    logic c_busy = 1'b0;
    int   c_cnt  = 0;
    int   c_lat  = 0;
    int   lat_fixed = 0;   // -1 selects random latency

    function automatic int pick_lat();
        return ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 4));
    endfunction

    task automatic compare_outputs();
        check("pc_out", PC_out, exp_pc_out);
        check("instr_out", instr_out, exp_instr);
        check("icache_read", {31'd0, icache.icache_read}, {31'd0, !m_held});
        if (!m_held)
            check("icache_addr", icache.icache_addr, m_stale ? m_stale_addr : m_pc);
`ifdef IF_PERF_CNT_EN
        check("perf_fetch_cnt", perf_fetch_cnt, exp_fetch);
        check("perf_stall_cnt", perf_stall_cnt, exp_stall);
`endif
    endtask

    // One clock cycle: called just after a falling edge, returns just after
    // the next falling edge with all registered outputs compared.
    task automatic tick(input logic r, input logic b, input logic m,
                        input logic bt, input logic [31:0] tg);
        logic        resp;
        logic [31:0] rdata;
        logic        adv;
        logic        stall_now;

        rst       = r;
        bubble    = b;
        MA_stall  = m;
        br_taken  = bt;
        br_target = tg;

        if (icache.icache_read === 1'b1 && !c_busy) begin
            c_busy = 1'b1;
            c_cnt  = 0;
            c_lat  = (lat_fixed >= 0) ? lat_fixed : pick_lat();
        end
        resp  = (icache.icache_read === 1'b1) && c_busy && (c_cnt == c_lat);
        rdata = resp ? mem_word(icache.icache_addr) : $urandom;
        icache.icache_resp  = resp;
        icache.icache_rdata = rdata;

        adv       = !m && !b;
        stall_now = !bt && adv && (m_stale || (!m_held && !resp));
        #1;
        if (!r) check("if_stall", {31'd0, IF_stall}, {31'd0, stall_now});

        @(posedge clk);

        if (resp || r) c_busy = 1'b0;
        else if (c_busy) c_cnt++;

        if (r) begin
            m_pc       = RESET_PC;
            m_stale    = 1'b0;
            m_held     = 1'b0;
            exp_pc_out = '0;
            exp_instr  = NOP;
            exp_fetch  = '0;
            exp_stall  = '0;
        end else begin
            if (stall_now) exp_stall = exp_stall + 32'd1;
            if (bt) begin
                exp_pc_out = '0;
                exp_instr  = NOP;
                if (m_held) m_held = 1'b0;
                else if (m_stale) begin
                    if (resp) m_stale = 1'b0;
                end else if (!resp) begin
                    m_stale      = 1'b1;
                    m_stale_addr = m_pc;
                end
                m_pc = tg;
            end else if (m_held) begin
                if (adv) begin
                    exp_pc_out = m_pc;
                    exp_instr  = m_held_word;
                    exp_fetch  = exp_fetch + 32'd1;
                    m_pc       = m_pc + 32'd4;
                    m_held     = 1'b0;
                end
            end else if (m_stale) begin
                if (resp) m_stale = 1'b0;
                if (adv) begin
                    exp_pc_out = '0;
                    exp_instr  = NOP;
                end
            end else if (resp) begin
                if (adv) begin
                    exp_pc_out = m_pc;
                    exp_instr  = rdata;
                    exp_fetch  = exp_fetch + 32'd1;
                    m_pc       = m_pc + 32'd4;
                end else begin
                    m_held      = 1'b1;
                    m_held_word = rdata;
                end
            end else if (adv) begin
                exp_pc_out = '0;
                exp_instr  = NOP;
            end
        end

        @(negedge clk);
        compare_outputs();
    endtask

    task automatic go();
        tick(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    initial begin
        rst = 1'b1; bubble = 1'b0; MA_stall = 1'b0; br_taken = 1'b0; br_target = '0;
        icache.icache_resp = 1'b0; icache.icache_rdata = '0;
        m_pc = RESET_PC; m_stale = 1'b0; m_stale_addr = '0; m_held = 1'b0; m_held_word = '0;
        exp_pc_out = '0; exp_instr = NOP; exp_fetch = '0; exp_stall = '0;
        @(negedge clk);

        // Reset state
        lat_fixed = 0;
        tick(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        check("rst_pc_out", PC_out, 32'h0);
        check("rst_instr", instr_out, 32'h13);
        check("rst_read", {31'd0, icache.icache_read}, 32'd1);
        check("rst_addr", icache.icache_addr, 32'h60);

        // Single-cycle hits stream one per cycle
        go();
        check("stream_pc0", PC_out, 32'h60);
        check("stream_instr0", instr_out, mem_word(32'h60));
        check("stream_addr1", icache.icache_addr, 32'h64);
        go();
        check("stream_pc1", PC_out, 32'h64);
        check("stream_addr2", icache.icache_addr, 32'h68);

        // Back-pressure while a response arrives: word is held
        tick(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        check("held_read", {31'd0, icache.icache_read}, 32'd0);
        check("held_pc", PC_out, 32'h64);
        tick(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        check("held_pc_still", PC_out, 32'h64);
        go();
        check("released_pc", PC_out, 32'h68);
        check("released_instr", instr_out, mem_word(32'h68));
        check("resume_addr", icache.icache_addr, 32'h6C);

        // Redirect during a 4-cycle miss: address stays until the response
        lat_fixed = 3;
        go();
        check("miss_nop", instr_out, 32'h13);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 32'h200);
        check("drop_addr_hold", icache.icache_addr, 32'h6C);
        check("drop_flush_pc", PC_out, 32'h0);
        go();
        check("drop_addr_hold2", icache.icache_addr, 32'h6C);
        go();
        check("redirect_addr", icache.icache_addr, 32'h200);
        check("redirect_instr", instr_out, 32'h13);

        // Redirect coinciding with a hit and adv: response is not delivered
        lat_fixed = 0;
        tick(1'b0, 1'b0, 1'b0, 1'b1, 32'h300);
        check("br_hit_pc", PC_out, 32'h0);
        check("br_hit_instr", instr_out, 32'h13);
        check("br_hit_addr", icache.icache_addr, 32'h300);
        go();
        check("after_br_pc", PC_out, 32'h300);

        // Reset during an outstanding miss; the response in the reset cycle is ignored
        lat_fixed = 2;
        go();
        go();
        tick(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        check("midrst_addr", icache.icache_addr, 32'h60);
        check("midrst_instr", instr_out, 32'h13);
        check("midrst_pc", PC_out, 32'h0);
        lat_fixed = 0;
        go();
        check("postrst_pc", PC_out, 32'h60);

        // PC wraps modulo 2^32; misaligned target passes through
        tick(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        check("wrap_addr0", icache.icache_addr, 32'hFFFF_FFFC);
        go();
        check("wrap_pc", PC_out, 32'hFFFF_FFFC);
        check("wrap_addr1", icache.icache_addr, 32'h0);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 32'h302);
        check("misalign_addr", icache.icache_addr, 32'h302);

        // Redirect while a word is held discards it
        tick(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        tick(1'b0, 1'b1, 1'b0, 1'b1, 32'h400);
        check("held_br_read", {31'd0, icache.icache_read}, 32'd1);
        check("held_br_addr", icache.icache_addr, 32'h400);
        check("held_br_instr", instr_out, 32'h13);

`ifdef IF_PERF_CNT_EN
        // Six starved cycles then ten delivered instructions
        lat_fixed = 6;
        tick(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 7; i++) go();
        lat_fixed = 0;
        for (int i = 0; i < 9; i++) go();
        check("perf_fetch_10", perf_fetch_cnt, 32'd10);
        check("perf_stall_6", perf_stall_cnt, 32'd6);
`endif

        // Randomized run
        lat_fixed = -1;
        for (int i = 0; i < 3000; i++) begin
            logic        r, b, m, bt;
            logic [31:0] tg;
            r  = ($urandom_range(0, 99) < 1);
            b  = ($urandom_range(0, 99) < 25);
            m  = ($urandom_range(0, 99) < 15);
            bt = ($urandom_range(0, 99) < 8);
            case ($urandom_range(0, 9))
                0:       tg = 32'hFFFF_FFF0 + {28'd0, 2'($urandom_range(0, 3)), 2'b00};
                1:       tg = {16'd0, 16'($urandom)};
                default: tg = {16'd0, 14'($urandom), 2'b00};
            endcase
            tick(r, b, m, bt, tg);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
